instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 SHALL have parameter IWIDTH, default 32, instruction width.
REQ-002 SHALL have parameter AWIDTH, default 32, instruction address width.
REQ-003 SHALL have parameter PC_WIDTH, default 32, program counter width.
REQ-004 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-005 SHALL have parameter PC_STEP, default 4, PC increment per fetched instruction.
REQ-006 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-007 SHALL have port f_clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port f_rst  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port f_o_addr_instr  output  AWIDTH  fetch address to instruction memory.
REQ-010 SHALL have port f_o_syn  output  1  fetch request, held until acknowledged.
REQ-011 SHALL have port f_i_ack  input  1  memory acknowledge; f_i_instr valid this cycle.
REQ-012 SHALL have port f_i_instr  input  IWIDTH  instruction from memory.
REQ-013 SHALL have port f_change_pc  input  1  redirect/flush request.
REQ-014 SHALL have port f_alu_pc_value  input  PC_WIDTH  redirect target.
REQ-015 SHALL have port f_i_stall  input  1  downstream stall; hold output stage.
REQ-016 SHALL have port f_o_instr  output  IWIDTH  instruction to decode.
REQ-017 SHALL have port f_pc  output  PC_WIDTH  address of f_o_instr.
REQ-018 SHALL have port f_o_ce  output  1  f_o_instr/f_pc valid.
REQ-019 SHALL have port f_o_count  output  clog2(DEPTH)+1  buffer occupancy.

Function
REQ-020 SHALL keep a fetch PC; f_o_addr_instr equals fetch PC (truncated/zero-extended to AWIDTH).
REQ-021 SHALL assert f_o_syn whenever occupancy < DEPTH and not in reset; f_o_syn low when full.
REQ-022 SHALL, on edge with f_o_syn & f_i_ack & !f_change_pc: push {fetch PC, f_i_instr}, fetch PC += PC_STEP (mod 2^PC_WIDTH).
REQ-023 SHALL ignore f_i_ack while f_o_syn low.
REQ-024 SHALL hold f_o_addr_instr stable while f_o_syn high and no ack and no redirect.
REQ-025 SHALL, on edge with f_i_stall low and buffer non-empty: load head into f_o_instr/f_pc, set f_o_ce, pop.
REQ-026 SHALL, on edge with f_i_stall low and buffer empty: clear f_o_ce (f_o_instr/f_pc hold).
REQ-027 SHALL, on edge with f_i_stall high: hold f_o_instr, f_pc, f_o_ce, no pop; fetching continues until full.
REQ-028 SHALL allow push and pop on the same edge; occupancy unchanged.
REQ-029 SHALL, on edge with f_change_pc: empty buffer, clear f_o_ce, fetch PC = f_alu_pc_value; a same-cycle ack is discarded; f_i_stall ignored.
REQ-030 SHALL present redirect target on f_o_addr_instr with f_o_syn high the cycle after f_change_pc, replacing any unacknowledged request.
REQ-031 SHALL give latency: ack at edge E -> f_o_ce high after edge E+1 (buffer empty, no stall).
REQ-032 SHALL apply priority reset > f_change_pc > f_i_stall.
REQ-033 SHALL drive f_o_count as registered occupancy, 0..DEPTH.

Reset
REQ-034 SHALL, while f_rst low: fetch PC = RESET_PC, f_o_syn 0, buffer empty, f_o_count 0, f_o_ce 0, f_o_instr 0, f_pc 0.
REQ-035 SHALL assert f_o_syn with address RESET_PC in the first cycle after f_rst rises.
REQ-036 SHALL abandon any in-flight request on reset mid-operation; no stale data after release.

Structure
REQ-037 SHALL place default PC_STEP and RESET_PC constants in the shared core package.
REQ-038 SHALL implement the buffer as sub-module fetch_fifo (synchronous FIFO, entry {pc, instr}, flush input, full/empty/count).
REQ-039 SHALL keep handshake, PC and output-stage logic in instruction_prefetch.

Verification
REQ-040 SHALL cover reset then acks A0A0A0A0, B1B1B1B1, C2C2C2C2 -> f_o_instr in order, f_pc 0x0, 0x4, 0x8, f_o_ce high one cycle after each push.
REQ-041 SHALL cover stall held 6 cycles with continuous ack, DEPTH=4 -> f_o_syn drops at f_o_count 4, outputs frozen, 4 instrs drain in order after release.
REQ-042 SHALL cover f_change_pc with f_alu_pc_value 0x100 while 3 buffered -> f_o_ce low next cycle, f_o_count 0, f_o_addr_instr 0x100, next f_pc 0x100 then 0x104.
REQ-043 SHALL cover f_change_pc coincident with ack of D3D3D3D3 -> D3D3D3D3 never appears on f_o_instr.
REQ-044 SHALL cover fetch PC 0xFFFFFFFC acked -> next f_o_addr_instr 0x00000000.
REQ-045 SHALL cover f_rst low mid-stall with 2 buffered -> all outputs reset values; after release f_o_addr_instr 0x0, f_o_syn 1.

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// Shared core constants for the instruction prefetch unit.
// Default PC step and reset fetch address live here so every user agrees.
package instruction_prefetch_pkg;
  localparam int unsigned     DEF_PC_STEP  = 4;
  localparam longint unsigned DEF_RESET_PC = 64'h0;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the prefetch unit.
// Flush clears all entries and overrides any push/pop on the same edge.
module fetch_fifo
  import instruction_prefetch_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DW-1:0]                 din_i,
  output logic [DW-1:0]                 dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [count_width(DEPTH)-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: issues sequential fetches, buffers returned
// instructions in fetch_fifo, and feeds a stallable output stage to decode.
module instruction_prefetch
  import instruction_prefetch_pkg::*;
#(
  parameter int unsigned     IWIDTH   = 32,
  parameter int unsigned     AWIDTH   = 32,
  parameter int unsigned     PC_WIDTH = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = DEF_PC_STEP,
  parameter longint unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                          f_clk,
  input  logic                          f_rst,
  output logic [AWIDTH-1:0]             f_o_addr_instr,
  output logic                          f_o_syn,
  input  logic                          f_i_ack,
  input  logic [IWIDTH-1:0]             f_i_instr,
  input  logic                          f_change_pc,
  input  logic [PC_WIDTH-1:0]           f_alu_pc_value,
  input  logic                          f_i_stall,
  output logic [IWIDTH-1:0]             f_o_instr,
  output logic [PC_WIDTH-1:0]           f_pc,
  output logic                          f_o_ce,
  output logic [count_width(DEPTH)-1:0] f_o_count
);
  localparam int unsigned EW = PC_WIDTH + IWIDTH;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                ce_q, ce_d;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [EW-1:0]       fifo_dout;

  // Memory handshake: f_o_syn requests f_o_addr_instr and stays up with a
  // stable address until f_i_ack; an ack only transfers data while f_o_syn is
  // high, and an ack coinciding with a redirect is dropped.
  assign f_o_syn        = f_rst && !fifo_full;
  assign f_o_addr_instr = AWIDTH'(pc_q);
  assign push           = f_o_syn && f_i_ack && !f_change_pc;
  assign pop            = !f_change_pc && !f_i_stall && !fifo_empty;

  fetch_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (f_clk),
    .rst_ni  (f_rst),
    .flush_i (f_change_pc),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({pc_q, f_i_instr}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (f_o_count)
  );

  always_comb begin
    pc_d = pc_q;
    if (f_change_pc)  pc_d = f_alu_pc_value;
    else if (push)    pc_d = pc_q + PC_WIDTH'(PC_STEP);
  end

  // Redirect kills the output stage; otherwise a stall freezes it.
  always_comb begin
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    ce_d     = ce_q;
    if (f_change_pc) begin
      ce_d = 1'b0;
    end else if (!f_i_stall) begin
      if (!fifo_empty) begin
        {out_pc_d, instr_d} = fifo_dout;
        ce_d                = 1'b1;
      end else begin
        ce_d = 1'b0;
      end
    end
  end

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      pc_q     <= PC_WIDTH'(RESET_PC);
      instr_q  <= '0;
      out_pc_q <= '0;
      ce_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      ce_q     <= ce_d;
    end
  end

  assign f_o_instr = instr_q;
  assign f_pc      = out_pc_q;
  assign f_o_ce    = ce_q;
endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: in-order delivery, stall/backpressure,
// redirect flush, dropped ack on redirect, PC wrap and mid-operation reset.
module tb_instruction_prefetch;
  logic        f_clk = 1'b0;
  logic        f_rst;
  logic [31:0] f_o_addr_instr;
  logic        f_o_syn;
  logic        f_i_ack;
  logic [31:0] f_i_instr;
  logic        f_change_pc;
  logic [31:0] f_alu_pc_value;
  logic        f_i_stall;
  logic [31:0] f_o_instr;
  logic [31:0] f_pc;
  logic        f_o_ce;
  logic [2:0]  f_o_count;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  always #5 f_clk = ~f_clk;

  instruction_prefetch dut (
    .f_clk          (f_clk),
    .f_rst          (f_rst),
    .f_o_addr_instr (f_o_addr_instr),
    .f_o_syn        (f_o_syn),
    .f_i_ack        (f_i_ack),
    .f_i_instr      (f_i_instr),
    .f_change_pc    (f_change_pc),
    .f_alu_pc_value (f_alu_pc_value),
    .f_i_stall      (f_i_stall),
    .f_o_instr      (f_o_instr),
    .f_pc           (f_pc),
    .f_o_ce         (f_o_ce),
    .f_o_count      (f_o_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ce, input logic [31:0] instr,
                           input logic [31:0] pc);
    check({tag, "_ce"}, 64'(f_o_ce), 64'(ce));
    check({tag, "_instr"}, 64'(f_o_instr), 64'(instr));
    check({tag, "_pc"}, 64'(f_pc), 64'(pc));
  endtask

  initial begin
    f_rst = 1'b0; f_i_ack = 1'b0; f_i_instr = '0; f_change_pc = 1'b0;
    f_alu_pc_value = '0; f_i_stall = 1'b0;
    tick(); tick();
    check("rst_syn", 64'(f_o_syn), 64'd0);
    check("rst_count", 64'(f_o_count), 64'd0);
    check_out("rst", 1'b0, 32'h0, 32'h0);

    // In-order delivery, one cycle after each push
    f_rst = 1'b1; #1;
    check("rel_syn", 64'(f_o_syn), 64'd1);
    check("rel_addr", 64'(f_o_addr_instr), 64'h0);
    f_i_ack = 1'b1; f_i_instr = 32'hA0A0A0A0; tick();
    check("p0_count", 64'(f_o_count), 64'd1);
    check("p0_addr", 64'(f_o_addr_instr), 64'h4);
    check("p0_ce", 64'(f_o_ce), 64'd0);
    f_i_instr = 32'hB1B1B1B1; tick();
    check_out("o0", 1'b1, 32'hA0A0A0A0, 32'h0);
    f_i_instr = 32'hC2C2C2C2; tick();
    check_out("o1", 1'b1, 32'hB1B1B1B1, 32'h4);
    f_i_ack = 1'b0; tick();
    check_out("o2", 1'b1, 32'hC2C2C2C2, 32'h8);
    tick();
    check_out("o_empty", 1'b0, 32'hC2C2C2C2, 32'h8);

    // Stall with continuous ack; fill to DEPTH then drain
    f_i_stall = 1'b1; f_i_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      f_i_instr = 32'h1000_0000 + k;
      if (k < 4) exp_q.push_back(f_i_instr);
      tick();
      check("st_count", 64'(f_o_count), 64'((k < 3) ? k + 1 : 4));
      check_out("st_frz", 1'b0, 32'hC2C2C2C2, 32'h8);
    end
    check("st_syn", 64'(f_o_syn), 64'd0);
    check("st_addr", 64'(f_o_addr_instr), 64'd28);
    f_i_stall = 1'b0; f_i_ack = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_out("drain", 1'b1, exp_q.pop_front(), 32'(12 + 4 * j));
      check("drain_count", 64'(f_o_count), 64'(3 - j));
    end
    tick();
    check("drain_done_ce", 64'(f_o_ce), 64'd0);

    // Redirect with 3 buffered and a valid output
    f_i_ack = 1'b1; f_i_instr = 32'h2000_0000; tick();
    f_i_instr = 32'h2000_0001; tick();
    f_i_stall = 1'b1; f_i_instr = 32'h2000_0002; tick();
    f_i_instr = 32'h2000_0003; tick();
    check("rd_pre_count", 64'(f_o_count), 64'd3);
    check_out("rd_pre", 1'b1, 32'h2000_0000, 32'd28);
    f_i_ack = 1'b0; f_change_pc = 1'b1; f_alu_pc_value = 32'h100; tick();
    check("rd_ce", 64'(f_o_ce), 64'd0);
    check("rd_count", 64'(f_o_count), 64'd0);
    check("rd_addr", 64'(f_o_addr_instr), 64'h100);
    check("rd_syn", 64'(f_o_syn), 64'd1);
    f_change_pc = 1'b0; f_i_stall = 1'b0; f_i_ack = 1'b1; f_i_instr = 32'hE0E0E0E0; tick();
    check("rd_addr2", 64'(f_o_addr_instr), 64'h104);
    f_i_instr = 32'hE1E1E1E1; tick();
    check_out("rd_o0", 1'b1, 32'hE0E0E0E0, 32'h100);
    f_i_ack = 1'b0; tick();
    check_out("rd_o1", 1'b1, 32'hE1E1E1E1, 32'h104);
    tick();

    // Ack coincident with redirect is discarded
    f_change_pc = 1'b1; f_alu_pc_value = 32'h200; f_i_ack = 1'b1; f_i_instr = 32'hD3D3D3D3;
    tick();
    check("dr_count", 64'(f_o_count), 64'd0);
    check("dr_addr", 64'(f_o_addr_instr), 64'h200);
    f_change_pc = 1'b0; f_i_ack = 1'b0; tick();
    check("dr_count2", 64'(f_o_count), 64'd0);
    check("dr_ce", 64'(f_o_ce), 64'd0);
    f_i_ack = 1'b1; f_i_instr = 32'hF0F0F0F0; tick();
    f_i_ack = 1'b0; tick();
    check_out("dr_o", 1'b1, 32'hF0F0F0F0, 32'h200);

    // Fetch PC wraps to zero
    f_change_pc = 1'b1; f_alu_pc_value = 32'hFFFFFFFC; tick();
    check("wr_addr0", 64'(f_o_addr_instr), 64'hFFFFFFFC);
    f_change_pc = 1'b0; f_i_ack = 1'b1; f_i_instr = 32'h5A5A5A5A; tick();
    check("wr_addr1", 64'(f_o_addr_instr), 64'h0);
    f_i_ack = 1'b0; tick();
    check_out("wr_o", 1'b1, 32'h5A5A5A5A, 32'hFFFFFFFC);

    // Reset mid-stall with 2 buffered
    f_i_stall = 1'b1; f_i_ack = 1'b1; f_i_instr = 32'h66666666; tick();
    f_i_instr = 32'h77777777; tick();
    check("mr_pre_count", 64'(f_o_count), 64'd2);
    f_rst = 1'b0; #1;
    check("mr_count", 64'(f_o_count), 64'd0);
    check("mr_syn", 64'(f_o_syn), 64'd0);
    check("mr_addr", 64'(f_o_addr_instr), 64'h0);
    check_out("mr", 1'b0, 32'h0, 32'h0);
    tick();
    check("mr_hold_count", 64'(f_o_count), 64'd0);
    f_rst = 1'b1; f_i_stall = 1'b0; f_i_ack = 1'b0; #1;
    check("mr_rel_syn", 64'(f_o_syn), 64'd1);
    check("mr_rel_addr", 64'(f_o_addr_instr), 64'h0);
    tick();
    check("mr_rel_count", 64'(f_o_count), 64'd0);
    check_out("mr_rel", 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
